// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared types and constants for the RV32-subset multi-cycle control path.
//   - ctrl_state_e : controller FSM states (3-bit encoding, visible on the
//                    debug state port)
//   - opclass_e    : instruction classes the controller can sequence
//   - OPC_*        : inst[6:4] codes that select each class
//                    (inst[1:0] must also be 2'b11)
// ----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } ctrl_state_e;

  typedef enum logic [2:0] {
    R       = 3'd0,
    IALU    = 3'd1,
    LOAD    = 3'd2,
    STORE   = 3'd3,
    BRANCH  = 3'd4,
    ILLEGAL = 3'd5
  } opclass_e;

  localparam logic [2:0] OPC_R      = 3'b011;
  localparam logic [2:0] OPC_IALU   = 3'b001;
  localparam logic [2:0] OPC_LOAD   = 3'b000;
  localparam logic [2:0] OPC_STORE  = 3'b010;
  localparam logic [2:0] OPC_BRANCH = 3'b110;

endpackage

// File: rtl/opclass_decode.sv
// ----------------------------------------------------------------------------
// opclass_decode
//   Combinational instruction classifier.
//   Ports:
//     opc_i     in  3  inst[6:4], selects the class
//     quad_i    in  2  inst[1:0], must be 2'b11 for any legal 32-bit opcode
//     opclass_o out    decoded class; ILLEGAL for anything unsupported
// ----------------------------------------------------------------------------
module opclass_decode
  import riscv_pkg::*;
(
  input  logic [2:0] opc_i,
  input  logic [1:0] quad_i,
  output opclass_e   opclass_o
);

  always_comb begin
    opclass_o = ILLEGAL;
    if (quad_i == 2'b11) begin
      case (opc_i)
        OPC_R:      opclass_o = R;
        OPC_IALU:   opclass_o = IALU;
        OPC_LOAD:   opclass_o = LOAD;
        OPC_STORE:  opclass_o = STORE;
        OPC_BRANCH: opclass_o = BRANCH;
        default:    opclass_o = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle control FSM for the RV32 subset core (R, I-ALU, LOAD, STORE,
//   BRANCH). Sequences FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> IDLE and
//   owns the instruction register.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     en                          run enable, sampled only in IDLE
//     imem_req/imem_ready/rdata   instruction fetch handshake
//     inst                        instruction register
//     pc_we, pc_sel               PC write strobe / source (1 = branch target)
//     alu_src_imm, alu_sub        ALU operand-B select / compare mode
//     br_taken                    branch condition, valid in EXEC
//     dmem_req/dmem_we/dmem_ready data memory handshake
//     rf_we, wb_sel_mem           register-file write strobe / source select
//     halted                      illegal instruction seen, sticky until rst
//     state                       current FSM state (debug)
//   Optional build macro CTRL_PERF_EN adds cyc_cnt and ret_cnt counters.
// ----------------------------------------------------------------------------
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] inst,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             alu_src_imm,
  output logic             alu_sub,
  input  logic             br_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             wb_sel_mem,
  output logic             halted,
  output logic [2:0]       state
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] cyc_cnt,
  output logic [CNT_WIDTH-1:0] ret_cnt
`endif
);

  // Opcode fields are sliced from inst[6:0], and counters need at least a bit.
  if (WIDTH < 7) begin : g_bad_width
    $error("multicycle_ctrl: WIDTH must be at least 7");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("multicycle_ctrl: CNT_WIDTH must be at least 1");
  end

  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  opclass_e         opclass;

  // The IR is frozen from DECODE onward, so the class can be re-derived from
  // it in every later state instead of being stored separately.
  opclass_decode u_decode (
    .opc_i     (inst_q[6:4]),
    .quad_i    (inst_q[1:0]),
    .opclass_o (opclass)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    imem_req    = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 1'b0;
    alu_src_imm = 1'b0;
    alu_sub     = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    wb_sel_mem  = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_d  = imem_rdata;
          pc_we   = 1'b1;          // PC <= PC + 4
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = (opclass == ILLEGAL) ? HALT : EXEC;
      end
      EXEC: begin
        alu_src_imm = (opclass == IALU) || (opclass == LOAD) || (opclass == STORE);
        case (opclass)
          BRANCH: begin
            alu_sub = 1'b1;
            if (br_taken) begin
              pc_we  = 1'b1;
              pc_sel = 1'b1;
            end
            state_d = IDLE;
          end
          LOAD, STORE: state_d = MEM;
          R, IALU:     state_d = WB;
          default:     state_d = HALT;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opclass == STORE);
        if (dmem_ready) state_d = (opclass == STORE) ? IDLE : WB;
      end
      WB: begin
        rf_we      = 1'b1;
        wb_sel_mem = (opclass == LOAD);
        state_d    = IDLE;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;            // unused encoding: recover to IDLE
      end
    endcase
  end

  assign inst   = inst_q;
  assign halted = (state_q == HALT);
  assign state  = state_q;

`ifdef CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] cyc_cnt_q, ret_cnt_q;
  logic                 retire;

  // Final cycle of each instruction: WB, a completing store, or a branch EXEC.
  assign retire = (state_q == WB)
               || ((state_q == MEM) && dmem_ready && (opclass == STORE))
               || ((state_q == EXEC) && (opclass == BRANCH));

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      if (state_q != IDLE && state_q != HALT) cyc_cnt_q <= cyc_cnt_q + CNT_WIDTH'(1);
      if (retire)                             ret_cnt_q <= ret_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each step advances one clock, drives
//   the inputs for the new cycle, and checks state plus a packed control
//   vector against hand-computed values.
//   ctl bit order: {imem_req, pc_we, pc_sel, alu_src_imm, alu_sub,
//                   dmem_req, dmem_we, rf_we, wb_sel_mem, halted}
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  localparam logic [31:0] I_ADDI = 32'h0050_0093;
  localparam logic [31:0] I_LW   = 32'h0000_2103;
  localparam logic [31:0] I_SW   = 32'h0020_2023;
  localparam logic [31:0] I_BEQ  = 32'h0000_0463;
  localparam logic [31:0] I_ZERO = 32'h0000_0000;

  localparam logic [9:0] C_NONE   = 10'b00_0000_0000;
  localparam logic [9:0] C_FETCH  = 10'b10_0000_0000;  // waiting on imem
  localparam logic [9:0] C_FETCHD = 10'b11_0000_0000;  // imem_ready: pc_we, pc_sel=0
  localparam logic [9:0] C_EXIMM  = 10'b00_0100_0000;
  localparam logic [9:0] C_BRNT   = 10'b00_0010_0000;
  localparam logic [9:0] C_BRT    = 10'b01_1010_0000;
  localparam logic [9:0] C_LDMEM  = 10'b00_0001_0000;
  localparam logic [9:0] C_STMEM  = 10'b00_0001_1000;
  localparam logic [9:0] C_WBALU  = 10'b00_0000_0100;
  localparam logic [9:0] C_WBLD   = 10'b00_0000_0110;
  localparam logic [9:0] C_HALT   = 10'b00_0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] imem_rdata = 32'h0;

  logic        imem_req, pc_we, pc_sel, alu_src_imm, alu_sub;
  logic        dmem_req, dmem_we, rf_we, wb_sel_mem, halted;
  logic [31:0] inst;
  logic [2:0]  state;
`ifdef CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  logic [9:0]  ctl;
  assign ctl = {imem_req, pc_we, pc_sel, alu_src_imm, alu_sub,
                dmem_req, dmem_we, rf_we, wb_sel_mem, halted};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .alu_src_imm (alu_src_imm),
    .alu_sub     (alu_sub),
    .br_taken    (br_taken),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .rf_we       (rf_we),
    .wb_sel_mem  (wb_sel_mem),
    .halted      (halted),
    .state       (state)
`ifdef CTRL_PERF_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .ret_cnt     (ret_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  // Advance one clock, then drive this cycle's inputs and let them settle.
  task automatic step(input logic r, input logic e, input logic ir,
                      input logic dr, input logic br);
    @(posedge clk);
    #1;
    rst        = r;
    en         = e;
    imem_ready = ir;
    dmem_ready = dr;
    br_taken   = br;
    #1;
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [9:0] c);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctl"},   32'(ctl),   32'(c));
  endtask

  // PC and register-file writes must never coincide.
  always @(negedge clk) begin
    if (!rst) check("pc_rf_excl", 32'(pc_we & rf_we), 32'h0);
  end

  initial begin
    // ---- reset ----
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    expect_cyc("rst", IDLE, C_NONE);
    check("rst_inst", inst, 32'h0);
`ifdef CTRL_PERF_EN
    check("rst_cyc", cyc_cnt, 32'd0);
    check("rst_ret", ret_cnt, 32'd0);
`endif

    // ---- ADDI, zero-wait; en dropped after FETCH ----
    imem_rdata = I_ADDI;
    step(0, 1, 1, 0, 0); expect_cyc("addi_idle", IDLE, C_NONE);   // ready ignored in IDLE
    step(0, 1, 1, 0, 0); expect_cyc("addi_fetch", FETCH, C_FETCHD);
    step(0, 0, 1, 0, 0); expect_cyc("addi_dec", DECODE, C_NONE);
    check("addi_inst", inst, I_ADDI);
    step(0, 0, 1, 0, 0); expect_cyc("addi_exec", EXEC, C_EXIMM);
    step(0, 0, 0, 0, 0); expect_cyc("addi_wb", WB, C_WBALU);
    step(0, 0, 0, 0, 0); expect_cyc("addi_end", IDLE, C_NONE);
`ifdef CTRL_PERF_EN
    check("addi_ret", ret_cnt, 32'd1);
    check("addi_cyc", cyc_cnt, 32'd4);
`endif
    step(0, 0, 0, 0, 0); expect_cyc("addi_stay", IDLE, C_NONE);
    $display("txn ADDI done");

    // ---- reset while FETCH waits on imem ----
    imem_rdata = I_LW;
    step(0, 1, 0, 0, 0); expect_cyc("rf_idle", IDLE, C_NONE);
    step(0, 1, 0, 0, 0); expect_cyc("rf_fetch", FETCH, C_FETCH);
    check("rf_hold_inst", inst, I_ADDI);                           // rdata ignored without ready
    step(1, 1, 0, 0, 0); expect_cyc("rf_rst_cyc", FETCH, C_FETCH);
    step(0, 0, 0, 0, 0); expect_cyc("rf_after", IDLE, C_NONE);
    check("rf_inst", inst, 32'h0);
    $display("txn reset-in-FETCH done");

    // ---- LW, dmem_ready after 3 wait cycles ----
    step(0, 1, 1, 0, 0); expect_cyc("lw_idle", IDLE, C_NONE);
    step(0, 0, 1, 0, 0); expect_cyc("lw_fetch", FETCH, C_FETCHD);
    step(0, 0, 1, 1, 0); expect_cyc("lw_dec", DECODE, C_NONE);     // dmem_ready ignored
    check("lw_inst", inst, I_LW);
    step(0, 0, 0, 0, 0); expect_cyc("lw_exec", EXEC, C_EXIMM);
    step(0, 0, 0, 0, 0); expect_cyc("lw_mem1", MEM, C_LDMEM);
    step(0, 0, 0, 0, 0); expect_cyc("lw_mem2", MEM, C_LDMEM);
    step(0, 0, 0, 0, 0); expect_cyc("lw_mem3", MEM, C_LDMEM);
    step(0, 0, 0, 1, 0); expect_cyc("lw_mem4", MEM, C_LDMEM);
    step(0, 0, 0, 0, 0); expect_cyc("lw_wb", WB, C_WBLD);
    check("lw_wb_inst", inst, I_LW);
    step(0, 0, 0, 0, 0); expect_cyc("lw_end", IDLE, C_NONE);
    $display("txn LW done");

    // ---- SW, zero-wait ----
    imem_rdata = I_SW;
    step(0, 1, 1, 0, 0); expect_cyc("sw_idle", IDLE, C_NONE);
    step(0, 0, 1, 1, 0); expect_cyc("sw_fetch", FETCH, C_FETCHD);
    step(0, 0, 0, 1, 0); expect_cyc("sw_dec", DECODE, C_NONE);
    step(0, 0, 0, 1, 0); expect_cyc("sw_exec", EXEC, C_EXIMM);
    step(0, 0, 0, 1, 0); expect_cyc("sw_mem", MEM, C_STMEM);
    step(0, 0, 0, 0, 0); expect_cyc("sw_end", IDLE, C_NONE);
    $display("txn SW done");

    // ---- BEQ taken ----
    imem_rdata = I_BEQ;
    step(0, 1, 1, 0, 0); expect_cyc("bt_idle", IDLE, C_NONE);
    step(0, 0, 1, 0, 0); expect_cyc("bt_fetch", FETCH, C_FETCHD);
    step(0, 0, 0, 0, 0); expect_cyc("bt_dec", DECODE, C_NONE);
    step(0, 0, 0, 0, 1); expect_cyc("bt_exec", EXEC, C_BRT);
    step(0, 0, 0, 0, 0); expect_cyc("bt_end", IDLE, C_NONE);
    $display("txn BEQ taken done");

    // ---- BEQ not taken ----
    step(0, 1, 1, 0, 0); expect_cyc("bn_idle", IDLE, C_NONE);
    step(0, 0, 1, 0, 0); expect_cyc("bn_fetch", FETCH, C_FETCHD);
    step(0, 0, 0, 0, 1); expect_cyc("bn_dec", DECODE, C_NONE);
    step(0, 0, 0, 0, 0); expect_cyc("bn_exec", EXEC, C_BRNT);
    step(0, 0, 0, 0, 0); expect_cyc("bn_end", IDLE, C_NONE);
    $display("txn BEQ not-taken done");

    // ---- illegal word -> HALT, sticky until rst ----
    imem_rdata = I_ZERO;
    step(0, 1, 1, 0, 0); expect_cyc("il_idle", IDLE, C_NONE);
    step(0, 0, 1, 0, 0); expect_cyc("il_fetch", FETCH, C_FETCHD);
    step(0, 1, 1, 1, 1); expect_cyc("il_dec", DECODE, C_NONE);
    for (int i = 0; i < 4; i++) begin
      step(0, i[0], ~i[0], i[0], 1);
      expect_cyc("il_halt", HALT, C_HALT);
    end
    step(1, 1, 1, 1, 1); expect_cyc("il_rst_cyc", HALT, C_HALT);
    step(0, 0, 0, 0, 0); expect_cyc("il_after", IDLE, C_NONE);
    check("il_inst", inst, 32'h0);
    $display("txn illegal/HALT done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
